servo_pose_sequencer: RTL
=========================

// Module: servo_pose_sequencer
// PURPOSE
//  Plays a stored list of arm poses on NUM_JOINTS servo PWM channels. Each joint moves toward its target at most STEP counts per frame.
//  Sits above the per-joint PWM generators: drives each channel's pulse-width value and enable, replacing push-button jogging.
//  Pose table is written by the host/config logic. Playback is started and stopped by the user-control FSM.
// PARAMETERS
//  NUM_JOINTS    4          servo channels driven
//  NUM_POSES     8          pose table depth (power of 2)
//  PW_W          20         pulse-width/counter width, in clk cycles
//  FRAME_CYCLES  1_000_000  clk cycles per servo frame (20 ms @ 50 MHz)
//  PULSE_MIN     25_000     minimum legal pulse width, clk cycles
//  PULSE_MAX     125_000    maximum legal pulse width, clk cycles
//  STEP          500        maximum change per joint per frame, clk cycles
//  DWELL_FRAMES  25         frames held at a reached pose before advancing
// PORTS
//  clk           in   1                   system clock
//  rst           in   1                   asynchronous, active-low reset
//  start         in   1                   1-cycle pulse: begin playback at pose 0
//  stop          in   1                   1-cycle pulse: abort playback, freeze outputs
//  loop_en       in   1                   1 = wrap from last pose back to pose 0
//  num_poses     in   log2(NUM_POSES)+1   poses used, 1..NUM_POSES (0 treated as 1)
//  wr_en         in   1                   pose-table write strobe
//  wr_pose       in   log2(NUM_POSES)     pose index to write
//  wr_joint      in   log2(NUM_JOINTS)    joint index to write
//  wr_data       in   PW_W                target pulse width
//  wr_err        out  1                   1-cycle pulse: write rejected (busy)
//  pulse_width   out  NUM_JOINTS*PW_W     flat per-joint pulse width; joint j at [j*PW_W +: PW_W]
//  servo_en      out  NUM_JOINTS          per-joint PWM enable
//  busy          out  1                   high in LOAD/RAMP/DWELL
//  done          out  1                   1-cycle pulse when the last pose's dwell ends (loop_en=0)
//  pose_idx      out  log2(NUM_POSES)     pose currently targeted
//  frame_tick    out  1                   1-cycle pulse at end of each frame
// BEHAVIOUR
//  Reset (async, rst=0):
//   - all pulse_width = PULSE_MIN; servo_en=0; busy=done=wr_err=0; pose_idx=0; state IDLE; frame counter=0.
//   - Pose table contents are not reset.
//  Frame counter: free-running 0..FRAME_CYCLES-1. frame_tick=1 in the cycle where count==FRAME_CYCLES-1.
//  Table write: on wr_en with busy=0, store clamp(wr_data, PULSE_MIN, PULSE_MAX) next cycle. With busy=1, ignore the write and pulse wr_err.
//  FSM:
//   - IDLE: start -> LOAD with pose_idx=0.
//   - LOAD (1 cycle): latch the table row for pose_idx into the target regs; servo_en all 1 -> RAMP.
//   - RAMP: on each frame_tick, every joint with pw<tgt does pw+=min(STEP, tgt-pw); every joint with pw>tgt does pw-=min(STEP, pw-tgt).
//     When all pw==tgt after an update -> DWELL; dwell counter=0.
//   - DWELL: counter increments on frame_tick. At DWELL_FRAMES ticks:
//     - if pose_idx < num_poses-1: pose_idx+1 -> LOAD;
//     - else if loop_en: pose_idx=0 -> LOAD;
//     - else: pulse done -> IDLE.
//  IDLE after playback: pulse_width and servo_en hold their last values. Servos stay powered at the last pose until reset.
//  stop in any busy state -> IDLE next cycle; pulse_width frozen; servo_en held; done not pulsed.
//  start while busy is ignored. start and stop in the same cycle: stop wins.
//  Pulse-width arithmetic is unsigned PW_W bits; no overshoot; outputs never leave [PULSE_MIN, PULSE_MAX].
//  A pose equal to the current position reaches DWELL at the first frame_tick in RAMP.
//  num_poses > NUM_POSES saturates to NUM_POSES.
// TESTING (FRAME_CYCLES=10, PULSE_MIN=1000, PULSE_MAX=5000, STEP=100, DWELL_FRAMES=2, NUM_JOINTS=2)
//  1. Reset mid-RAMP (rst low 1 cycle) -> pulse_width={1000,1000}, servo_en=0, busy=0, same cycle.
//  2. Write pose0={1250,1000}, start -> j0 goes 1100,1200,1250 on successive ticks; j1 stays 1000; DWELL, then done pulse after 2 ticks.
//  3. Write wr_data=9000 and wr_data=10 -> readback via playback gives 5000 and 1000 (clamped).
//  4. wr_en during busy -> wr_err=1 for 1 cycle; table unchanged (next playback unaffected).
//  5. num_poses=2, loop_en=1 -> pose_idx sequence 0,1,0,1...; done never pulses; stop -> busy=0 next cycle, outputs frozen.
//  6. start and stop in the same cycle from IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/servo_pose_sequencer.sv
// Servo pose sequencer: plays a stored pose table onto per-joint
// PWM pulse widths, rate-limited to STEP counts per frame.
module servo_pose_sequencer #(
  parameter int NUM_JOINTS   = 4,
  parameter int NUM_POSES    = 8,
  parameter int PW_W         = 20,
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int PULSE_MIN    = 25_000,
  parameter int PULSE_MAX    = 125_000,
  parameter int STEP         = 500,
  parameter int DWELL_FRAMES = 25,
  localparam int PI_W =
    (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1,
  localparam int JI_W =
    (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [PI_W:0]              num_poses,
  input  logic                       wr_en,
  input  logic [PI_W-1:0]            wr_pose,
  input  logic [JI_W-1:0]            wr_joint,
  input  logic [PW_W-1:0]            wr_data,
  output logic                       wr_err,
  output logic [NUM_JOINTS*PW_W-1:0] pulse_width,
  output logic [NUM_JOINTS-1:0]      servo_en,
  output logic                       busy,
  output logic                       done,
  output logic [PI_W-1:0]            pose_idx,
  output logic                       frame_tick
);

  localparam int FC_W =
    (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int DW_W = $clog2(DWELL_FRAMES + 1);

  localparam logic [PW_W-1:0] P_MIN  = PW_W'(PULSE_MIN);
  localparam logic [PW_W-1:0] P_MAX  = PW_W'(PULSE_MAX);
  localparam logic [PW_W-1:0] P_STEP = PW_W'(STEP);
  localparam logic [FC_W-1:0] FC_LAST =
    FC_W'(FRAME_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST =
    DW_W'(DWELL_FRAMES - 1);
  localparam logic [PI_W:0] NP_MAX = (PI_W+1)'(NUM_POSES);
  localparam logic [PI_W:0] NP_ONE = (PI_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RAMP,
    DWELL
  } state_t;

  state_t state, state_nxt;

  logic [FC_W-1:0] fcnt;
  logic [DW_W-1:0] dwell_cnt;
  logic [PW_W-1:0] tbl [NUM_POSES][NUM_JOINTS];
  logic [PW_W-1:0] pw      [NUM_JOINTS];
  logic [PW_W-1:0] tgt     [NUM_JOINTS];
  logic [PW_W-1:0] pw_nxt  [NUM_JOINTS];
  logic [PW_W-1:0] wr_clamped;
  logic [PI_W:0]   n_eff;
  logic [PI_W:0]   idx_p1;
  logic [PI_W-1:0] idx_nxt;
  logic            last_pose;
  logic            at_tgt;
  logic            do_load;
  logic            do_step;
  logic            dwell_clr;
  logic            dwell_inc;
  logic            done_nxt;

  assign frame_tick = (fcnt == FC_LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            fcnt <= '0;
    else if (frame_tick) fcnt <= '0;
    else                 fcnt <= fcnt + 1'b1;
  end

  always_comb begin
    wr_clamped = wr_data;
    if (wr_data < P_MIN) wr_clamped = P_MIN;
    if (wr_data > P_MAX) wr_clamped = P_MAX;
  end

  // Pose table is plain storage: never reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy)
      tbl[wr_pose][wr_joint] <= wr_clamped;
  end

  always_comb begin
    n_eff = num_poses;
    if (num_poses == '0)    n_eff = NP_ONE;
    if (num_poses > NP_MAX) n_eff = NP_MAX;
    idx_p1    = {1'b0, pose_idx} + NP_ONE;
    last_pose = (idx_p1 >= n_eff);
  end

  // Move each joint toward its target, never past it.
  always_comb begin
    at_tgt = 1'b1;
    for (int j = 0; j < NUM_JOINTS; j++) begin
      pw_nxt[j] = pw[j];
      unique case (1'b1)
        (pw[j] < tgt[j]):
          pw_nxt[j] = (tgt[j] - pw[j] > P_STEP) ?
                      pw[j] + P_STEP : tgt[j];
        (pw[j] > tgt[j]):
          pw_nxt[j] = (pw[j] - tgt[j] > P_STEP) ?
                      pw[j] - P_STEP : tgt[j];
        default: ;
      endcase
      if (pw_nxt[j] != tgt[j]) at_tgt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = pose_idx;
    do_load   = 1'b0;
    do_step   = 1'b0;
    dwell_clr = 1'b0;
    dwell_inc = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      LOAD: begin
        do_load   = 1'b1;
        state_nxt = RAMP;
      end
      RAMP: begin
        if (frame_tick) begin
          do_step = 1'b1;
          if (at_tgt) begin
            state_nxt = DWELL;
            dwell_clr = 1'b1;
          end
        end
      end
      DWELL: begin
        if (frame_tick) begin
          if (dwell_cnt != DW_LAST) begin
            dwell_inc = 1'b1;
          end else if (!last_pose) begin
            idx_nxt   = pose_idx + 1'b1;
            state_nxt = LOAD;
          end else if (loop_en) begin
            idx_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort freezes everything except the state itself.
    if (stop && busy) begin
      state_nxt = IDLE;
      idx_nxt   = pose_idx;
      do_load   = 1'b0;
      do_step   = 1'b0;
      dwell_clr = 1'b0;
      dwell_inc = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NUM_JOINTS; j++) begin
        pw[j]  <= P_MIN;
        tgt[j] <= P_MIN;
      end
      servo_en  <= '0;
      pose_idx  <= '0;
      dwell_cnt <= '0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_err   <= wr_en && busy;
      done     <= done_nxt;
      pose_idx <= idx_nxt;
      if (do_load) begin
        for (int j = 0; j < NUM_JOINTS; j++)
          tgt[j] <= tbl[pose_idx][j];
        servo_en <= '1;
      end
      if (do_step) begin
        for (int j = 0; j < NUM_JOINTS; j++)
          pw[j] <= pw_nxt[j];
      end
      if (dwell_clr)      dwell_cnt <= '0;
      else if (dwell_inc) dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_JOINTS; g++) begin : g_pw
    assign pulse_width[g*PW_W +: PW_W] = pw[g];
  end

endmodule
